// File: rtl/stream_pkg.sv
// Shared definitions for the stream word splitter: FSM state encoding and halfword geometry.
// No logic of its own; no latency.
// No backpressure; a declarations-only package.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_e;

    localparam int HW     = 16;
    localparam int WORD_W = 2 * HW;

    // Picks one half of a held word; upper=1 selects bits [31:16].
    function automatic logic [HW-1:0] half_sel(input logic [WORD_W-1:0] word, input logic upper);
        return upper ? word[WORD_W-1:HW] : word[HW-1:0];
    endfunction

endpackage

// File: rtl/stream_word_splitter.sv
// Splits 32-bit upstream FWFT words into two 16-bit FWFT halfwords and counts halfwords delivered.
// Latency: a word popped at cycle t shows its first half at t+1; the second half follows its pop.
// Backpressure: holds the current halfword while FIFO_READ_NEXT_IN is low; pops upstream only when a slot frees.
module stream_word_splitter
    import stream_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 ENABLE,
    input  logic [WORD_W-1:0]    IN_DATA,
    input  logic                 IN_EMPTY,
    output logic                 IN_READ_NEXT,
    output logic [HW-1:0]        FIFO_DATA_OUT,
    output logic                 FIFO_EMPTY_OUT,
    input  logic                 FIFO_READ_NEXT_IN,
    output logic [CNT_WIDTH-1:0] HALF_CNT
);

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 pop_dn;
    logic                 pop_up;

    assign pop_dn = FIFO_READ_NEXT_IN & (state_q != ST_IDLE);

    // Refilling in SECOND on the same cycle its last half leaves keeps the output gapless.
    assign pop_up = ENABLE & ~IN_EMPTY &
                    ((state_q == ST_IDLE) | ((state_q == ST_SECOND) & pop_dn));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = pop_dn ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_up) begin
                    state_d = ST_FIRST;
                    word_d  = IN_DATA;
                end
            end
            ST_FIRST: begin
                if (pop_dn) begin
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (pop_dn) begin
                    if (pop_up) begin
                        state_d = ST_FIRST;
                        word_d  = IN_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        FIFO_DATA_OUT = '0;
        case (state_q)
            ST_FIRST:  FIFO_DATA_OUT = half_sel(word_q, !LSB_FIRST);
            ST_SECOND: FIFO_DATA_OUT = half_sel(word_q, LSB_FIRST);
            default:   FIFO_DATA_OUT = '0;
        endcase
    end

    assign IN_READ_NEXT   = pop_up;
    assign FIFO_EMPTY_OUT = (state_q == ST_IDLE);
    assign HALF_CNT       = cnt_q;

endmodule
